// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Instruction fetch stage. Generates the program counter and
//                issues requests to instruction memory over a req/ack
//                handshake with variable latency. Presents one instruction
//                per cycle to the IF/ID register. Handles stall, MIPS-style
//                branch redirect (delay slot kept) and exception flush. A
//                one-entry skid buffer catches a response that lands while
//                the pipeline is stalled.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                stall              downstream is not capturing; hold outputs
//                flush, flush_pc    exception redirect (highest priority)
//                branch_flag,       taken branch from decode (one-cycle pulse)
//                branch_target
//                imem_req/addr      memory request (held until imem_ack)
//                imem_ack/rdata     memory response
//                if_pc/inst/valid   presented instruction (zero bubble)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam logic [31:0] c_zero_word = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_pc;          // next instruction not yet presented
    logic [31:0] r_drop_addr;   // address of an abandoned, still-open request
    logic [31:0] r_skid_addr;
    logic [31:0] r_skid_inst;
    logic        r_skid_full;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        r_if_valid;

    // Next-state values
    state_t      w_state_n;
    logic [31:0] w_pc_n;
    logic [31:0] w_drop_addr_n;
    logic [31:0] w_skid_addr_n;
    logic [31:0] w_skid_inst_n;
    logic        w_skid_full_n;
    logic [31:0] w_if_pc_n;
    logic [31:0] w_if_inst_n;
    logic        w_if_valid_n;

    logic        w_redirect;
    logic        w_ack_live;

    assign w_redirect = flush | branch_flag;

    // A response is only usable when it answers the current in-order
    // request (REQ) and no redirect makes it wrong-path this cycle.
    // Acks seen in IDLE/HOLD are ignored; acks in DROP are discarded.
    assign w_ack_live = (r_state == S_REQ) && imem_ack && !w_redirect;

    // ------------------------------------------------------------------
    // Memory interface: request is a pure function of the registered
    // state, so it can never be withdrawn before the ack.
    // ------------------------------------------------------------------
    assign imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;
    assign if_valid = r_if_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop_addr <= c_zero_word;
            r_skid_addr <= c_zero_word;
            r_skid_inst <= c_zero_word;
            r_skid_full <= 1'b0;
            r_if_pc     <= c_zero_word;
            r_if_inst   <= c_zero_word;
            r_if_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_drop_addr <= w_drop_addr_n;
            r_skid_addr <= w_skid_addr_n;
            r_skid_inst <= w_skid_inst_n;
            r_skid_full <= w_skid_full_n;
            r_if_pc     <= w_if_pc_n;
            r_if_inst   <= w_if_inst_n;
            r_if_valid  <= w_if_valid_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_drop_addr_n = r_drop_addr;
        w_skid_addr_n = r_skid_addr;
        w_skid_inst_n = r_skid_inst;
        w_skid_full_n = r_skid_full;
        w_if_pc_n     = r_if_pc;
        w_if_inst_n   = r_if_inst;
        w_if_valid_n  = r_if_valid;

        // --- sequencing ---
        case (r_state)
            S_IDLE: begin
                w_state_n = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    // A redirected ack is simply dropped; the new pc is
                    // requested next cycle.
                    w_state_n = S_REQ;
                    if (w_ack_live) begin
                        w_pc_n = r_pc + PC_STEP;
                        if (stall) begin
                            w_state_n = S_HOLD;
                        end
                    end
                end else if (w_redirect) begin
                    // The open request cannot be withdrawn: keep presenting
                    // its address until memory answers, then discard.
                    w_drop_addr_n = r_pc;
                    w_state_n     = S_DROP;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_state_n = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_state_n = S_REQ;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // --- skid capture: a usable response while stalled ---
        if (w_ack_live && stall) begin
            w_skid_addr_n = r_pc;
            w_skid_inst_n = imem_rdata;
            w_skid_full_n = 1'b1;
        end

        // --- presentation: skid first (older), then live ack, else bubble.
        // On a branch edge the delay slot has just been captured downstream,
        // and anything buffered behind it is wrong-path.
        if (!stall) begin
            if (r_skid_full && !w_redirect) begin
                w_if_pc_n     = r_skid_addr;
                w_if_inst_n   = r_skid_inst;
                w_if_valid_n  = 1'b1;
                w_skid_full_n = 1'b0;
            end else if (w_ack_live) begin
                w_if_pc_n    = r_pc;
                w_if_inst_n  = imem_rdata;
                w_if_valid_n = 1'b1;
            end else begin
                w_if_pc_n    = c_zero_word;
                w_if_inst_n  = c_zero_word;
                w_if_valid_n = 1'b0;
            end
        end

        // --- redirect: flush beats branch; both clear the skid ---
        if (w_redirect) begin
            w_pc_n        = flush ? flush_pc : branch_target;
            w_skid_full_n = 1'b0;
            if ((r_state == S_IDLE) || (r_state == S_HOLD)) begin
                w_state_n = S_REQ;
            end
        end

        // Flush kills the presented instruction even under stall.
        if (flush) begin
            w_if_pc_n    = c_zero_word;
            w_if_inst_n  = c_zero_word;
            w_if_valid_n = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Self-checking bench for inst_fetch_unit. A memory model with
//                programmable latency answers requests with addr^A5A5A5A5.
//                A transaction-level reference tracks which address must be
//                captured next by decode and checks every consumed
//                instruction, stall holds, flush bubbles and handshake rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC(RESET_PC),
        .PC_STEP (PC_STEP)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tb_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    // ---------------- memory model ----------------
    bit          busy = 0;        // a request is open and not yet acked
    bit          abandoned = 0;   // open request was redirected away from
    bit          ack_abandoned = 0;
    int          cnt = 0;
    int          lat = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic [31:0] req_addr = '0;

    task automatic mem_drive();
        imem_ack      = 1'b0;
        imem_rdata    = $urandom;
        ack_abandoned = 0;
        if (imem_req) begin
            if (!busy) begin
                busy     = 1;
                cnt      = 0;
                lat      = $urandom_range(lat_max, lat_min);
                req_addr = imem_addr;
            end else begin
                tb_check("addr_stable", {32'h0, imem_addr}, {32'h0, req_addr});
            end
            if (cnt == lat) begin
                imem_ack      = 1'b1;
                imem_rdata    = inst_of(req_addr);
                busy          = 0;
                ack_abandoned = abandoned;
                abandoned     = 0;
            end else begin
                cnt++;
            end
        end else if (busy) begin
            tb_check("req_withdrawn", {63'h0, imem_req}, 64'h1);
        end
    endtask

    // ---------------- reference: what decode must capture next ----------
    logic [31:0] exp_next = RESET_PC;
    bit          pending = 0;     // branch seen while delay slot held
    logic [31:0] pend_tgt = '0;
    int          idle_cnt = 0;

    logic [31:0] pre_pc, pre_inst, s_tgt, s_fpc;
    logic        pre_valid;
    bit          s_rst, s_stall, s_flush, s_branch, s_ack, s_ack_ab;

    task automatic model_update();
        if (s_rst) begin
            exp_next  = RESET_PC;
            pending   = 0;
            busy      = 0;
            abandoned = 0;
            idle_cnt  = 0;
            tb_check("rst_pc",    {32'h0, if_pc},   64'h0);
            tb_check("rst_inst",  {32'h0, if_inst}, 64'h0);
            tb_check("rst_valid", {63'h0, if_valid}, 64'h0);
            tb_check("rst_req",   {63'h0, imem_req}, 64'h0);
        end else if (s_flush) begin
            tb_check("flush_valid", {63'h0, if_valid}, 64'h0);
            exp_next = s_fpc;
            pending  = 0;
            idle_cnt = 0;
        end else if (s_stall) begin
            tb_check("stall_hold", {if_pc, if_inst}, {pre_pc, pre_inst});
            tb_check("stall_hold_valid", {63'h0, if_valid}, {63'h0, pre_valid});
            if (s_branch) begin
                pending  = 1;
                pend_tgt = s_tgt;
            end
            if (s_ack && !s_ack_ab && !s_branch)
                tb_check("skid_full_req", {63'h0, imem_req}, 64'h0);
        end else begin
            if (pre_valid) begin
                tb_check("seq_pc",   {32'h0, pre_pc},   {32'h0, exp_next});
                tb_check("seq_inst", {32'h0, pre_inst}, {32'h0, inst_of(pre_pc)});
                exp_next = s_branch ? s_tgt : (pending ? pend_tgt : pre_pc + PC_STEP);
                pending  = 0;
                idle_cnt = 0;
                if (s_branch) tb_check("branch_bubble", {63'h0, if_valid}, 64'h0);
            end else begin
                idle_cnt++;
            end
            if (idle_cnt > 40) begin
                tb_check("progress", 64'(idle_cnt), 64'h0);
                idle_cnt = 0;
            end
        end
        if (!if_valid) tb_check("bubble_zero", {if_pc, if_inst}, 64'h0);
        if (!s_rst && (s_flush || s_branch) && busy) abandoned = 1;
    endtask

    // One clock: memory answers, snapshot, edge, check. Returns at negedge.
    task automatic step();
        mem_drive();
        pre_pc   = if_pc;    pre_inst = if_inst;  pre_valid = if_valid;
        s_rst    = rst;      s_stall  = stall;    s_flush   = flush;
        s_branch = branch_flag;
        s_tgt    = branch_target;
        s_fpc    = flush_pc;
        s_ack    = imem_ack;
        s_ack_ab = ack_abandoned;
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20; k++) begin
            step();
            if (if_valid) break;
        end
        tb_check(tag, {63'h0, if_valid}, 64'h1);
    endtask

    task automatic random_inputs();
        rst           = ($urandom_range(499, 0) == 0);
        stall         = ($urandom_range(99, 0) < 30);
        flush         = ($urandom_range(999, 0) < 10);
        flush_pc      = $urandom & 32'hFFFF_FFFC;
        branch_target = $urandom & 32'hFFFF_FFFC;
        branch_flag   = if_valid && !pending && ($urandom_range(99, 0) < 8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int since;
        int seen;
        bit found;
        logic [31:0] skid_exp;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
        flush_pc = '0; branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);

        // ---- reset, first-instruction latency, zero-wait streaming ----
        lat_min = 0; lat_max = 0;
        repeat (3) step();
        rst = 1'b0;
        step();
        tb_check("first_edge_valid", {63'h0, if_valid}, 64'h0);
        tb_check("first_edge_req",   {63'h0, imem_req}, 64'h1);
        tb_check("first_edge_addr",  {32'h0, imem_addr}, {32'h0, RESET_PC});
        step();
        tb_check("first_inst_pc",    {32'h0, if_pc}, {32'h0, RESET_PC});
        tb_check("first_inst_valid", {63'h0, if_valid}, 64'h1);
        for (int i = 1; i < 4; i++) begin
            step();
            tb_check("zw_pc",    {32'h0, if_pc}, {32'h0, RESET_PC + 32'(i) * PC_STEP});
            tb_check("zw_valid", {63'h0, if_valid}, 64'h1);
        end

        // ---- 3-cycle memory: two bubbles after every instruction ----
        lat_min = 2; lat_max = 2;
        since = 0; seen = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            since++;
            if (if_valid) begin
                if (seen >= 2) tb_check("lat3_gap", 64'(since), 64'd3);
                seen++;
                since = 0;
            end
        end

        // ---- stall 4 cycles, ack lands in stall cycle 2 -> skid ----
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (imem_req && !busy) begin found = 1; break; end
            step();
        end
        tb_check("find_new_req", {63'h0, found}, 64'h1);
        skid_exp = imem_addr;
        stall = 1'b1;
        step();
        step();
        tb_check("hold_req_c2", {63'h0, imem_req}, 64'h0);
        step();
        tb_check("hold_req_c3", {63'h0, imem_req}, 64'h0);
        step();
        tb_check("hold_req_c4", {63'h0, imem_req}, 64'h0);
        stall = 1'b0;
        step();
        tb_check("skid_out_pc",    {32'h0, if_pc}, {32'h0, skid_exp});
        tb_check("skid_out_valid", {63'h0, if_valid}, 64'h1);

        // ---- branch at if_pc=0x10 with 0x14 outstanding ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (if_valid && if_pc == 32'h10) begin found = 1; break; end
            step();
        end
        tb_check("find_pc10", {63'h0, found}, 64'h1);
        tb_check("br_open_addr", {32'h0, imem_addr}, 64'h14);
        branch_flag = 1'b1; branch_target = 32'h200; stall = 1'b1;
        step();
        branch_flag = 1'b0; stall = 1'b0;
        tb_check("delay_slot_held", {32'h0, if_pc}, 64'h10);
        wait_valid("br_valid");
        tb_check("br_target_pc", {32'h0, if_pc}, 64'h200);

        // ---- flush + branch + stall while the skid is full ----
        lat_min = 0; lat_max = 0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (if_valid && imem_req && !busy) begin found = 1; break; end
            step();
        end
        tb_check("find_stream", {63'h0, found}, 64'h1);
        stall = 1'b1;
        step();
        tb_check("skid_hold_req", {63'h0, imem_req}, 64'h0);
        flush = 1'b1; flush_pc = 32'h180; branch_flag = 1'b1; branch_target = 32'h300;
        step();
        flush = 1'b0; branch_flag = 1'b0; stall = 1'b0;
        tb_check("flush_now_valid", {63'h0, if_valid}, 64'h0);
        wait_valid("flush_valid_after");
        tb_check("flush_target_pc", {32'h0, if_pc}, 64'h180);

        // ---- pc wrap through branch ----
        for (int k = 0; k < 10; k++) begin
            if (if_valid) break;
            step();
        end
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_flag = 1'b0;
        wait_valid("wrap_valid");
        tb_check("wrap_top_pc", {32'h0, if_pc}, 64'hFFFF_FFFC);
        step();
        tb_check("wrap_zero_pc",    {32'h0, if_pc}, 64'h0);
        tb_check("wrap_zero_valid", {63'h0, if_valid}, 64'h1);

        // ---- reset in the middle of a request ----
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 20; k++) begin
            if (imem_req && busy) break;
            step();
        end
        tb_check("mid_req_open", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        lat_min = 0; lat_max = 0;
        step();
        step();
        tb_check("restart_pc",    {32'h0, if_pc}, {32'h0, RESET_PC});
        tb_check("restart_valid", {63'h0, if_valid}, 64'h1);

        // ---- randomized traffic ----
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            step();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
